// File: rtl/line_memory.sv
// Last-level backing store: whole-line reads and writebacks behind the cache,
// one access at a time with a fixed wait latency before the single-cycle response.
module line_memory #(
   parameter int ADDRBITS  = 32,
   parameter int WORDBITS  = 32,
   parameter int LINEITEMS = 4,
   parameter int DEPTH     = 256,
   parameter int LATENCY   = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          request,
   input  logic [1:0]                    operation,
   input  logic [ADDRBITS-1:0]           addr,
   input  logic [LINEITEMS*WORDBITS-1:0] wdata,
   output logic [LINEITEMS*WORDBITS-1:0] rdata,
   output logic                          valid,
   output logic                          busy,
   output logic                          error,
   output logic                          evict,
   output logic                          invalidate,
   output logic [15:0]                   rd_count,
   output logic [15:0]                   wr_count
);

   localparam int LW      = LINEITEMS * WORDBITS;
   localparam int OFFBITS = $clog2(LW / 8);
   localparam int IDXBITS = $clog2(DEPTH);
   localparam int HIBASE  = OFFBITS + IDXBITS;
   localparam int CW      = $clog2(LATENCY + 1);

   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [1:0]           op_q, op_d;
   logic [IDXBITS-1:0]   idx_q, idx_d;
   logic [LW-1:0]        wdata_q, wdata_d;
   logic                 inrange_q, inrange_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, busy_d;
   logic                 error_q, error_d;
   logic [LW-1:0]        rdata_q, rdata_d;
   logic [15:0]          rd_count_q, rd_count_d;
   logic [15:0]          wr_count_q, wr_count_d;
   logic [DEPTH-1:0]     written_q, written_d;
   logic                 mem_we_s;
   logic [ADDRBITS-1:0]  addr_hi_s;

   logic [LW-1:0]        mem_q [DEPTH];

   assign addr_hi_s = addr >> HIBASE;

   // Next-state, latching and response computation for the access sequencer.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      inrange_d  = inrange_q;
      valid_d    = 1'b0;
      busy_d     = 1'b0;
      error_d    = 1'b0;
      rdata_d    = {LW{1'b0}};
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      written_d  = written_q;
      mem_we_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (request && (operation == OP_READ || operation == OP_WRITE)) begin
               op_d      = operation;
               idx_d     = addr[OFFBITS +: IDXBITS];
               wdata_d   = wdata;
               inrange_d = (addr_hi_s == {ADDRBITS{1'b0}});
               cnt_d     = CW'(LATENCY - 1);
               state_d   = S_WAIT;
               busy_d    = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            busy_d = 1'b1;
            if (cnt_q == {CW{1'b0}}) begin
               // Response is computed here so it is registered on entry to RESPOND.
               state_d = S_RESPOND;
               valid_d = 1'b1;
               error_d = ~inrange_q;
               if (inrange_q && op_q == OP_WRITE) begin
                  mem_we_s          = 1'b1;
                  written_d[idx_q]  = 1'b1;
                  wr_count_d        = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;
               end else if (inrange_q) begin
                  rdata_d    = written_q[idx_q] ? mem_q[idx_q] : {LW{1'b0}};
                  rd_count_d = (rd_count_q == 16'hFFFF) ? rd_count_q : rd_count_q + 16'd1;
               end else begin
                  rdata_d = {LW{1'b0}};
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RESPOND: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Sequencer state, latched request and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= {CW{1'b0}};
         op_q       <= 2'd0;
         idx_q      <= {IDXBITS{1'b0}};
         wdata_q    <= {LW{1'b0}};
         inrange_q  <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         error_q    <= 1'b0;
         rdata_q    <= {LW{1'b0}};
         rd_count_q <= 16'd0;
         wr_count_q <= 16'd0;
         written_q  <= {DEPTH{1'b0}};
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         inrange_q  <= inrange_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         error_q    <= error_d;
         rdata_q    <= rdata_d;
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
         written_q  <= written_d;
      end
   end

   // Line storage has no reset; the written bits mask stale contents instead.
   always_ff @(posedge clock) begin
      if (mem_we_s) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign rdata      = rdata_q;
   assign valid      = valid_q;
   assign busy       = busy_q;
   assign error      = error_q;
   assign evict      = 1'b0;
   assign invalidate = 1'b0;
   assign rd_count   = rd_count_q;
   assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_line_memory.sv
// Scoreboard bench for line_memory: a behavioural line store predicts each response,
// a negedge monitor pops and compares whenever valid is presented.
module tb_line_memory;

   localparam int AW  = 32;
   localparam int WB  = 32;
   localparam int LI  = 4;
   localparam int DP  = 256;
   localparam int LAT = 4;
   localparam int LW  = LI * WB;
   localparam int LINEBYTES = LW / 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          request = 1'b0;
   logic [1:0]    operation = 2'd0;
   logic [AW-1:0] addr = '0;
   logic [LW-1:0] wdata = '0;
   logic [LW-1:0] rdata;
   logic          valid, busy, error, evict, invalidate;
   logic [15:0]   rd_count, wr_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [LW-1:0] rdata;
      logic          err;
      logic [15:0]   rc;
      logic [15:0]   wc;
      int            cyc;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [LW-1:0] m_mem [DP];
   bit            m_wr [DP];
   logic [15:0]   m_rc = 16'd0;
   logic [15:0]   m_wc = 16'd0;

   line_memory #(.ADDRBITS(AW), .WORDBITS(WB), .LINEITEMS(LI), .DEPTH(DP), .LATENCY(LAT)) dut (
      .clock(clock), .reset(reset), .request(request), .operation(operation),
      .addr(addr), .wdata(wdata), .rdata(rdata), .valid(valid), .busy(busy),
      .error(error), .evict(evict), .invalidate(invalidate),
      .rd_count(rd_count), .wr_count(wr_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference: a flat array of lines indexed by byte address / line size.
   task automatic model(input logic [1:0] op, input logic [AW-1:0] a, input logic [LW-1:0] d, input int ec);
      exp_t e;
      longint unsigned ua = a;
      int idx = int'((ua / LINEBYTES) % DP);
      bit inr = (ua < longint'(DP) * LINEBYTES);
      e.err = !inr;
      e.rdata = '0;
      if (inr && op == 2'd2) begin
         m_mem[idx] = d;
         m_wr[idx] = 1'b1;
         if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
      end else if (inr) begin
         e.rdata = m_wr[idx] ? m_mem[idx] : '0;
         if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
      end
      e.rc = m_rc;
      e.wc = m_wc;
      e.cyc = ec;
      sb.push_back(e);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DP; i++) m_wr[i] = 1'b0;
      m_rc = 16'd0;
      m_wc = 16'd0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      @(negedge clock);
      while (busy !== 1'b0 && n < 60) begin
         @(negedge clock);
         n++;
      end
      if (n >= 60) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout busy=%b expected 0", busy);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [LW-1:0] d,
                        input bit hold, input bit expect_resp, input int exp_gap);
      int n;
      wait_idle(n);
      if (exp_gap >= 0) chk("busy_gap", LW'(n), LW'(exp_gap));
      request = 1'b1;
      operation = op;
      addr = a;
      wdata = d;
      if (expect_resp) model(op, a, d, cyc + 1 + LAT);
      @(posedge clock);
      #1;
      chk("accept_busy", LW'(busy), LW'(1));
      request = hold;
      operation = 2'($urandom);
      addr = $urandom;
      wdata = rand_line();
   endtask

   // Monitor: pop one expectation per valid pulse; outputs must be quiet otherwise.
   always @(negedge clock) begin
      if (reset) begin
         if (valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid valid=%b expected 0", valid);
            end else begin
               mon_e = sb.pop_front();
               chk("rdata", rdata, mon_e.rdata);
               chk("error", LW'(error), LW'(mon_e.err));
               chk("rd_count", LW'(rd_count), LW'(mon_e.rc));
               chk("wr_count", LW'(wr_count), LW'(mon_e.wc));
               chk("latency_cycle", LW'(cyc), LW'(mon_e.cyc));
               chk("busy_respond", LW'(busy), LW'(1));
            end
         end else begin
            chk("rdata_idle", rdata, '0);
            chk("error_idle", LW'(error), LW'(0));
         end
      end
   end

   initial begin
      int n;
      logic [AW-1:0] a;
      logic [LW-1:0] beef;
      beef = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
      model_reset();
      repeat (3) @(negedge clock);
      chk("rst_valid", LW'(valid), LW'(0));
      chk("rst_busy", LW'(busy), LW'(0));
      chk("rst_error", LW'(error), LW'(0));
      chk("rst_rdata", rdata, '0);
      chk("rst_rd_count", LW'(rd_count), LW'(0));
      chk("rst_wr_count", LW'(wr_count), LW'(0));
      chk("rst_tied", LW'({evict, invalidate}), LW'(0));
      reset = 1'b1;

      issue(2'd1, 32'h0000_0040, '0, 1'b0, 1'b1, -1);
      issue(2'd2, 32'h0000_0040, beef, 1'b0, 1'b1, -1);
      issue(2'd1, 32'h0000_0040, '0, 1'b0, 1'b1, -1);
      issue(2'd1, 32'h0001_0000, '0, 1'b0, 1'b1, -1);

      issue(2'd1, 32'h0000_0040, '0, 1'b1, 1'b1, -1);
      issue(2'd1, 32'h0000_0044, '0, 1'b1, 1'b1, LAT + 1);
      issue(2'd1, 32'h0000_0048, '0, 1'b0, 1'b1, LAT + 1);

      issue(2'd2, 32'h0000_0030, rand_line(), 1'b0, 1'b0, -1);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("abort_busy", LW'(busy), LW'(0));
      chk("abort_valid", LW'(valid), LW'(0));
      model_reset();
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (LAT + 3) @(negedge clock);
      issue(2'd1, 32'h0000_0030, '0, 1'b0, 1'b1, -1);

      wait_idle(n);
      request = 1'b1;
      for (int i = 0; i < 10; i++) begin
         operation = (i % 2 == 0) ? 2'd0 : 2'd3;
         addr = $urandom;
         @(negedge clock);
         chk("nop_busy", LW'(busy), LW'(0));
      end
      request = 1'b0;
      chk("nop_rd_count", LW'(rd_count), LW'(m_rc));
      chk("nop_wr_count", LW'(wr_count), LW'(m_wc));

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            a = $urandom;
            if (a < DP * LINEBYTES) a = a | 32'h0010_0000;
         end else if ($urandom_range(0, 3) == 0) begin
            a = AW'($urandom_range(0, DP - 1) * LINEBYTES + $urandom_range(0, LINEBYTES - 1));
         end else begin
            a = AW'($urandom_range(0, 7) * LINEBYTES + $urandom_range(0, LINEBYTES - 1));
         end
         issue(2'($urandom_range(1, 2)), a, rand_line(), (i < 59) && ($urandom_range(0, 1) == 1), 1'b1, -1);
      end

      wait_idle(n);
      repeat (3) @(negedge clock);
      chk("scoreboard_empty", LW'(sb.size()), LW'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
